// File: rtl/phase_detector_tdc.sv
// Signed time-to-digital phase detector: counts fpga_clk cycles between matching edges of the
// reference and generated clocks, with lead/lag sign, saturation, missed-edge flag and averaging.
`timescale 1ns/1ps
module phase_detector_tdc #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_SEL    = 0,
  parameter int unsigned AVG_LOG2    = 2
) (
  input  logic             fpga_clk_i,
  input  logic             reset_n_i,
  input  logic             reference_i,
  input  logic             generated_i,
  output logic [WIDTH-1:0] pd_cycles_o,
  output logic             pd_valid_o,
  output logic             pd_sat_o,
  output logic             pd_missed_o,
  output logic [WIDTH-1:0] avg_cycles_o,
  output logic             avg_valid_o
);

  localparam logic [WIDTH-1:0] CntMax = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StRefFirst, StGenFirst} state_e;

  logic [SYNC_STAGES-1:0] ref_sync_q, gen_sync_q;
  logic                   ref_prev_q, gen_prev_q;
  logic                   ref_lvl, gen_lvl;
  logic                   ref_rise, ref_fall, gen_rise, gen_fall;
  logic                   ref_edge, gen_edge;

  state_e           state_q;
  logic             pol_q;
  logic [WIDTH-1:0] count_q, cnt_inc;
  logic [WIDTH-1:0] pd_cycles_q;
  logic             pd_valid_q, pd_sat_q, pd_missed_q;

  // Identical chains on both inputs keep their relative delay intact.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ref_sync_q <= '0;
      gen_sync_q <= '0;
      ref_prev_q <= 1'b0;
      gen_prev_q <= 1'b0;
    end else begin
      ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], reference_i};
      gen_sync_q <= {gen_sync_q[SYNC_STAGES-2:0], generated_i};
      ref_prev_q <= ref_lvl;
      gen_prev_q <= gen_lvl;
    end
  end

  assign ref_lvl  = ref_sync_q[SYNC_STAGES-1];
  assign gen_lvl  = gen_sync_q[SYNC_STAGES-1];
  assign ref_rise = ref_lvl & ~ref_prev_q;
  assign ref_fall = ~ref_lvl & ref_prev_q;
  assign gen_rise = gen_lvl & ~gen_prev_q;
  assign gen_fall = ~gen_lvl & gen_prev_q;

  assign ref_edge = (EDGE_SEL == 0) ? ref_rise :
                    (EDGE_SEL == 1) ? ref_fall : (ref_rise | ref_fall);
  assign gen_edge = (EDGE_SEL == 0) ? gen_rise :
                    (EDGE_SEL == 1) ? gen_fall : (gen_rise | gen_fall);

  assign cnt_inc = count_q + 1'b1;

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      pol_q       <= 1'b0;
      count_q     <= '0;
      pd_cycles_q <= '0;
      pd_valid_q  <= 1'b0;
      pd_sat_q    <= 1'b0;
      pd_missed_q <= 1'b0;
    end else begin
      pd_valid_q  <= 1'b0;
      pd_sat_q    <= 1'b0;
      pd_missed_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ref_edge && gen_edge && (ref_lvl == gen_lvl)) begin
            pd_cycles_q <= '0;
            pd_valid_q  <= 1'b1;
          end else if (ref_edge) begin
            state_q <= StRefFirst;
            count_q <= '0;
            pol_q   <= ref_lvl;
          end else if (gen_edge) begin
            state_q <= StGenFirst;
            count_q <= '0;
            pol_q   <= gen_lvl;
          end
        end
        StRefFirst: begin
          if (gen_edge && (gen_lvl == pol_q)) begin
            pd_cycles_q <= cnt_inc;
            pd_valid_q  <= 1'b1;
            state_q     <= StIdle;
          end else if (ref_edge) begin
            pd_missed_q <= 1'b1;
            count_q     <= '0;
            pol_q       <= ref_lvl;
          end else if (cnt_inc == CntMax) begin
            pd_cycles_q <= CntMax;
            pd_valid_q  <= 1'b1;
            pd_sat_q    <= 1'b1;
            state_q     <= StIdle;
          end else begin
            count_q <= cnt_inc;
          end
        end
        StGenFirst: begin
          if (ref_edge && (ref_lvl == pol_q)) begin
            pd_cycles_q <= -cnt_inc;
            pd_valid_q  <= 1'b1;
            state_q     <= StIdle;
          end else if (gen_edge) begin
            pd_missed_q <= 1'b1;
            count_q     <= '0;
            pol_q       <= gen_lvl;
          end else if (cnt_inc == CntMax) begin
            pd_cycles_q <= -CntMax;
            pd_valid_q  <= 1'b1;
            pd_sat_q    <= 1'b1;
            state_q     <= StIdle;
          end else begin
            count_q <= cnt_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pd_cycles_o = pd_cycles_q;
  assign pd_valid_o  = pd_valid_q;
  assign pd_sat_o    = pd_sat_q;
  assign pd_missed_o = pd_missed_q;

  if (AVG_LOG2 > 0) begin : g_avg
    localparam int unsigned AccW = WIDTH + AVG_LOG2;

    logic [AccW-1:0]     acc_q, acc_sum;
    logic [AVG_LOG2-1:0] win_q;
    logic [WIDTH-1:0]    avg_q;
    logic                avg_valid_q;
    logic                unused_sum_lsb;

    assign acc_sum        = acc_q + {{AVG_LOG2{pd_cycles_q[WIDTH-1]}}, pd_cycles_q};
    assign unused_sum_lsb = ^acc_sum[AVG_LOG2-1:0];

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        acc_q       <= '0;
        win_q       <= '0;
        avg_q       <= '0;
        avg_valid_q <= 1'b0;
      end else begin
        avg_valid_q <= 1'b0;
        if (pd_valid_q) begin
          if (win_q == '1) begin
            // Dropping the low bits of the two's-complement sum floors toward -inf.
            avg_q       <= acc_sum[AccW-1:AVG_LOG2];
            avg_valid_q <= 1'b1;
            acc_q       <= '0;
            win_q       <= '0;
          end else begin
            acc_q <= acc_sum;
            win_q <= win_q + 1'b1;
          end
        end
      end
    end

    assign avg_cycles_o = avg_q;
    assign avg_valid_o  = avg_valid_q;
  end else begin : g_no_avg
    assign avg_cycles_o = pd_cycles_q;
    assign avg_valid_o  = pd_valid_q;
  end

endmodule

// File: tb/tb_phase_detector_tdc.sv
// Directed bench for phase_detector_tdc: rising-edge unit with averaging plus a both-edges unit.
`timescale 1ns/1ps
module tb_phase_detector_tdc;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       reference, generated;
  logic [7:0] pd_cycles, avg_cycles, b_cycles, b_avg;
  logic       pd_valid, pd_sat, pd_missed, avg_valid;
  logic       b_valid, b_sat, b_missed, b_avg_valid;

  int n_vec = 0;
  int n_bad = 0;

  // Waveform generator configuration (written only by the main sequence).
  int cfg_p = 80, cfg_h = 40, cfg_off = 0, cfg_step = 0, cfg_rise = 0, cfg_fall = 0;
  bit cfg_hold = 0, cfg_asym = 0, gen_en = 0;
  int ph = -13;
  int p, pg, k, off;

  phase_detector_tdc #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_SEL(0), .AVG_LOG2(2)) dut (
    .fpga_clk_i  (clk),
    .reset_n_i   (reset_n),
    .reference_i (reference),
    .generated_i (generated),
    .pd_cycles_o (pd_cycles),
    .pd_valid_o  (pd_valid),
    .pd_sat_o    (pd_sat),
    .pd_missed_o (pd_missed),
    .avg_cycles_o(avg_cycles),
    .avg_valid_o (avg_valid)
  );

  phase_detector_tdc #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_SEL(2), .AVG_LOG2(2)) dut_both (
    .fpga_clk_i  (clk),
    .reset_n_i   (reset_n),
    .reference_i (reference),
    .generated_i (generated),
    .pd_cycles_o (b_cycles),
    .pd_valid_o  (b_valid),
    .pd_sat_o    (b_sat),
    .pd_missed_o (b_missed),
    .avg_cycles_o(b_avg),
    .avg_valid_o (b_avg_valid)
  );

  always #1.25 clk = ~clk;

  // Inputs change shortly after each rising edge; ph is the fpga cycle index of the waveform.
  always @(posedge clk) begin
    #0.3;
    if (!gen_en) begin
      ph = -13;
      reference = 1'b0;
      generated = 1'b0;
    end else begin
      ph++;
      p = ((ph % cfg_p) + cfg_p) % cfg_p;
      reference = (p < cfg_h);
      if (cfg_hold) begin
        generated = 1'b0;
      end else if (cfg_asym) begin
        generated = (p >= cfg_rise) && (p < cfg_h + cfg_fall);
      end else begin
        // Offset switches a quarter period before the reference rise, while both are low.
        k = (ph + cfg_p / 4 + 100 * cfg_p) / cfg_p;
        off = cfg_off + cfg_step * (k % 2);
        pg = (((ph - off) % cfg_p) + cfg_p) % cfg_p;
        generated = (pg < cfg_h);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input bit sel, input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? b_valid : pd_valid) && n < budget);
    check(tag, sel ? b_valid : pd_valid, 1);
  endtask

  task automatic restart(input int per, input int high, input int offs, input int step,
                         input bit hold, input bit asym, input int rise, input int fall);
    @(negedge clk);
    gen_en  = 0;
    reset_n = 0;
    repeat (3) @(negedge clk);
    cfg_p = per; cfg_h = high; cfg_off = offs; cfg_step = step;
    cfg_hold = hold; cfg_asym = asym; cfg_rise = rise; cfg_fall = fall;
    reset_n = 1;
    @(negedge clk);
    gen_en = 1;
  endtask

  initial begin
    int nv, nm, n;
    logic [7:0] exp_a [4];
    reset_n = 0;
    repeat (2) @(negedge clk);
    check("rst_cycles", pd_cycles, 0);
    check("rst_valid", pd_valid, 0);
    check("rst_sat", pd_sat, 0);
    check("rst_missed", pd_missed, 0);
    check("rst_avg", avg_cycles, 0);
    check("rst_avg_valid", avg_valid, 0);

    // Generated lags by 10 cycles.
    restart(80, 40, 10, 0, 0, 0, 0, 0);
    wait_valid(0, 200, "s1_valid");
    check("s1_cycles", pd_cycles, 8'h0A);
    check("s1_sat", pd_sat, 0);
    nv = 0; nm = 0;
    repeat (120) begin
      @(negedge clk);
      nv += int'(pd_valid);
      nm += int'(pd_missed);
    end
    check("s1_one_per_period", nv, 1);
    check("s1_no_missed", nm, 0);
    wait_valid(0, 200, "s1_valid3");
    wait_valid(0, 200, "s1_valid4");
    @(negedge clk);
    check("s1_avg_valid", avg_valid, 1);
    check("s1_avg", avg_cycles, 8'h0A);

    // Generated leads by 6 cycles.
    restart(80, 40, -6, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      wait_valid(0, 200, "s2_valid");
      check("s2_cycles", pd_cycles, 8'hFA);
    end
    check("s2_avg_not_yet", avg_valid, 0);
    @(negedge clk);
    check("s2_avg_valid", avg_valid, 1);
    check("s2_avg", avg_cycles, 8'hFA);

    // Alternating +3/+4, then -3/-4.
    restart(80, 40, 3, 1, 0, 0, 0, 0);
    exp_a[0] = 8'h03; exp_a[1] = 8'h04; exp_a[2] = 8'h03; exp_a[3] = 8'h04;
    for (int i = 0; i < 4; i++) begin
      wait_valid(0, 200, "s3p_valid");
      check("s3p_cycles", pd_cycles, exp_a[i]);
    end
    @(negedge clk);
    check("s3p_avg_valid", avg_valid, 1);
    check("s3p_avg", avg_cycles, 8'h03);

    restart(80, 40, -3, -1, 0, 0, 0, 0);
    exp_a[0] = 8'hFD; exp_a[1] = 8'hFC; exp_a[2] = 8'hFD; exp_a[3] = 8'hFC;
    for (int i = 0; i < 4; i++) begin
      wait_valid(0, 200, "s3n_valid");
      check("s3n_cycles", pd_cycles, exp_a[i]);
    end
    @(negedge clk);
    check("s3n_avg_valid", avg_valid, 1);
    check("s3n_avg", avg_cycles, 8'hFC);

    // Generated held low: missed edges, then saturation with a long reference period.
    restart(80, 40, 0, 0, 1, 0, 0, 0);
    nv = 0; nm = 0;
    repeat (400) begin
      @(negedge clk);
      nv += int'(pd_valid);
      nm += int'(pd_missed);
    end
    check("s4_missed_count", nm, 4);
    check("s4_no_valid", nv, 0);

    restart(400, 200, 0, 0, 1, 0, 0, 0);
    wait_valid(0, 300, "s4_sat_valid");
    check("s4_sat_cycles", pd_cycles, 8'h7F);
    check("s4_sat_flag", pd_sat, 1);

    // Simultaneous edges, then both-edge mode with asymmetric offsets.
    restart(80, 40, 0, 0, 0, 0, 0, 0);
    wait_valid(0, 200, "s5_zero_valid");
    check("s5_zero_cycles", pd_cycles, 8'h00);
    check("s5_zero_sat", pd_sat, 0);

    restart(80, 40, 0, 0, 0, 1, 5, 8);
    exp_a[0] = 8'h05; exp_a[1] = 8'h08; exp_a[2] = 8'h05;
    for (int i = 0; i < 3; i++) begin
      wait_valid(1, 200, "s5_both_valid");
      check("s5_both_cycles", b_cycles, exp_a[i]);
    end

    // Reset mid-window and mid-measurement; next window uses only fresh samples.
    restart(80, 10, 30, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      wait_valid(0, 200, "s6_pre_valid");
      check("s6_pre_cycles", pd_cycles, 8'h1E);
    end
    n = 0;
    while (ph < 180 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("s6_reached_mid", ph, 180);
    reset_n = 0;
    #0.5;
    check("s6_rst_cycles", pd_cycles, 0);
    check("s6_rst_valid", pd_valid, 0);
    check("s6_rst_avg", avg_cycles, 0);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(0, 200, "s6_post_valid");
      check("s6_post_cycles", pd_cycles, 8'hCE);
      @(negedge clk);
      check("s6_avg_valid", avg_valid, (i == 3) ? 1 : 0);
    end
    check("s6_avg", avg_cycles, 8'hCE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_detector_tdc.md
Name: phase_detector_tdc

Overview:
- Parametrised, signed time-to-digital phase detector for the ADPLL loop; successor to the unsigned PhaseDetectorDL.
- Measures the fpga_clk cycle count between matching edges of the reference and generated clocks and reports magnitude plus sign (lead/lag).
- Adds a selectable edge mode, saturation, missed-edge detection and an optional power-of-two averaging stage.
- Output feeds the digital loop filter.

Parameters:
- WIDTH, 8, width of the signed per-sample output (two's complement).
- SYNC_STAGES, 2, flip-flop synchroniser depth on each async input (minimum 2).
- EDGE_SEL, 0, edges measured: 0 rising only, 1 falling only, 2 both.
- AVG_LOG2, 2, averaging window of 2^AVG_LOG2 samples; 0 bypasses averaging (avg outputs mirror the sample outputs).

Ports:
- fpga_clk_i  in  1  sampling/measurement clock.
- reset_n_i  in  1  asynchronous active-low reset.
- reference_i  in  1  reference clock, asynchronous to fpga_clk_i.
- generated_i  in  1  DCO clock, asynchronous to fpga_clk_i.
- pd_cycles_o  out  WIDTH  signed sample; positive means generated lags reference.
- pd_valid_o  out  1  one-cycle strobe when pd_cycles_o updates.
- pd_sat_o  out  1  sample was clipped; qualified by pd_valid_o.
- pd_missed_o  out  1  one-cycle pulse when an opening edge repeats before the closing edge.
- avg_cycles_o  out  WIDTH  signed window average.
- avg_valid_o  out  1  one-cycle strobe per completed window.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs 0.
  - Synchronisers cleared; edge-detect history cleared to 0.
  - FSM in IDLE; accumulator and window counter 0.
- Synchronisation and edge detection:
  - Both inputs pass through identical SYNC_STAGES chains, so relative delay is preserved.
  - An edge is detected in the cycle after the synchronised level changes.
  - Only edges selected by EDGE_SEL are qualified.
- FSM states: IDLE, REF_FIRST, GEN_FIRST.
  - IDLE, ref edge only: go to REF_FIRST; count = 0; store edge polarity.
  - IDLE, gen edge only: go to GEN_FIRST; count = 0; store edge polarity.
  - IDLE, both edges in the same cycle with the same polarity: emit sample 0; stay in IDLE.
  - REF_FIRST/GEN_FIRST: count increments by 1 every cycle.
  - Closing edge (other input, same polarity as stored): emit +count from REF_FIRST or -count from GEN_FIRST, where count is the value including the increment that cycle; return to IDLE. An opposite-polarity edge on the other input is ignored (relevant only when EDGE_SEL=2).
  - The first count on a closing edge detected one cycle after the opening edge is 1.
  - Repeated opening edge before the closing edge: pulse pd_missed_o; count restarts at 0; stay in the same state; stored polarity updates.
  - Closing edge and repeated opening edge in the same cycle: the closing edge wins and is emitted; the opening edge is not re-armed.
  - Saturation: once count reaches 2^(WIDTH-1)-1 and no closing edge is present, emit ±(2^(WIDTH-1)-1) with pd_sat_o=1 and return to IDLE.
- Output timing:
  - pd_cycles_o, pd_valid_o and pd_sat_o are registered; valid asserts the cycle after the closing edge is detected.
  - pd_cycles_o holds its value between strobes.
- Averaging (AVG_LOG2 > 0):
  - Accumulator is signed, WIDTH+AVG_LOG2 bits; it adds each valid sample.
  - On the 2^AVG_LOG2-th sample: avg_cycles_o = accumulator arithmetic-shifted right by AVG_LOG2 (floor toward -inf); avg_valid_o pulses one cycle after pd_valid_o; accumulator and counter clear.
  - Saturated samples are included at their clipped value.
- Reset mid-measurement or mid-window discards all partial state; no strobe is produced.

Test Plan:
1. fpga_clk 2.5 ns period; reference 5 MHz; generated identical but delayed 10 fpga cycles; EDGE_SEL=0 -> pd_cycles_o=+10 with one pd_valid_o per ref period; pd_sat_o=0.
2. Generated leads reference by 6 cycles -> pd_cycles_o=-6 (8'hFA); with AVG_LOG2=2, avg_cycles_o=-6 after the 4th sample, avg_valid_o one cycle after the 4th pd_valid_o.
3. Alternate samples +3, +4 over 4 samples -> avg_cycles_o=+3 (sum 14 >> 2); alternating -3, -4 -> avg_cycles_o=-4 (floor).
4. Hold generated low, reference toggling -> pd_missed_o pulses at every ref rising edge after the first; no pd_valid_o while period < 127 cycles. Reference period > 127 cycles, WIDTH=8 -> pd_cycles_o=+127 with pd_sat_o=1.
5. Both inputs rise in the same fpga cycle -> pd_cycles_o=0 and valid. EDGE_SEL=2 with rising offset +5 and falling offset +8 -> samples alternate +5, +8.
6. Assert reset_n_i low for 1 cycle mid-measurement and mid-window -> all outputs 0 immediately; next window needs a full 2^AVG_LOG2 fresh samples.
